// File: rtl/draw_engine.sv
// rtl/draw_engine.sv - rectangle pixel-sweep engine feeding the VGA adapter write port
module draw_engine #(
    parameter int          SCREEN_W   = 160,
    parameter int          SCREEN_H   = 120,
    parameter int          PADDLE_W   = 4,
    parameter int          PADDLE_H   = 16,
    parameter int          BALL_SIZE  = 4,
    parameter int          L_PADDLE_X = 4,
    parameter int          R_PADDLE_X = 152,
    parameter logic [2:0]  FG_COLOUR  = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] draw_state,
    input  logic [6:0] l_pad_y,
    input  logic [6:0] r_pad_y,
    input  logic [7:0] ball_x,
    input  logic [6:0] ball_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [1:0] cmd_q, cmd_d;
    logic [6:0] lpy_q, lpy_d;
    logic [6:0] rpy_q, rpy_d;
    logic [7:0] bx_q, bx_d;
    logic [6:0] by_q, by_d;

    logic [7:0] x0_q, x0_d;
    logic [6:0] y0_q, y0_d;
    logic [7:0] w_q, w_d;
    logic [6:0] h_q, h_d;
    logic [2:0] col_q, col_d;
    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;

    logic [7:0] last_x_q, last_x_d;
    logic [6:0] last_y_q, last_y_d;
    logic [2:0] last_col_q, last_col_d;

    logic [7:0] raw_x0, raw_w;
    logic [6:0] raw_y0, raw_h;
    logic [2:0] raw_col;
    logic [8:0] lim_x, lim_y;
    logic [7:0] clamp_x0;
    logic [6:0] clamp_y0;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic       end_col, end_row;

    // Rectangle selection for the latched command
    always_comb begin
        raw_x0  = 8'd0;
        raw_y0  = 7'd0;
        raw_w   = 8'(SCREEN_W);
        raw_h   = 7'(SCREEN_H);
        raw_col = 3'b000;
        case (cmd_q)
            2'b01: begin
                raw_x0  = 8'(L_PADDLE_X);
                raw_y0  = lpy_q;
                raw_w   = 8'(PADDLE_W);
                raw_h   = 7'(PADDLE_H);
                raw_col = FG_COLOUR;
            end
            2'b11: begin
                raw_x0  = 8'(R_PADDLE_X);
                raw_y0  = rpy_q;
                raw_w   = 8'(PADDLE_W);
                raw_h   = 7'(PADDLE_H);
                raw_col = FG_COLOUR;
            end
            2'b10: begin
                raw_x0  = bx_q;
                raw_y0  = by_q;
                raw_w   = 8'(BALL_SIZE);
                raw_h   = 7'(BALL_SIZE);
                raw_col = FG_COLOUR;
            end
            default: begin
                raw_x0  = 8'd0;
                raw_y0  = 7'd0;
                raw_w   = 8'(SCREEN_W);
                raw_h   = 7'(SCREEN_H);
                raw_col = 3'b000;
            end
        endcase
    end

    // Origins are pulled back so the rectangle always ends on-screen
    always_comb begin
        lim_x    = 9'(SCREEN_W) - {1'b0, raw_w};
        lim_y    = 9'(SCREEN_H) - {2'b00, raw_h};
        clamp_x0 = ({1'b0, raw_x0} > lim_x) ? lim_x[7:0] : raw_x0;
        clamp_y0 = ({2'b00, raw_y0} > lim_y) ? lim_y[6:0] : raw_y0;
    end

    always_comb begin
        pix_x   = x0_q + cx_q;
        pix_y   = y0_q + cy_q;
        end_col = (cx_q == w_q - 8'd1);
        end_row = (cy_q == h_q - 7'd1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SETUP;
            S_SETUP: state_d = S_DRAW;
            S_DRAW:  if (end_col && end_row) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        plot   = (state_q == S_DRAW);
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        x      = plot ? pix_x : last_x_q;
        y      = plot ? pix_y : last_y_q;
        colour = plot ? col_q : last_col_q;
    end

    always_comb begin
        cmd_d      = cmd_q;
        lpy_d      = lpy_q;
        rpy_d      = rpy_q;
        bx_d       = bx_q;
        by_d       = by_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        col_d      = col_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        last_x_d   = last_x_q;
        last_y_d   = last_y_q;
        last_col_d = last_col_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cmd_d = draw_state;
                    lpy_d = l_pad_y;
                    rpy_d = r_pad_y;
                    bx_d  = ball_x;
                    by_d  = ball_y;
                end
            end
            S_SETUP: begin
                x0_d  = clamp_x0;
                y0_d  = clamp_y0;
                w_d   = raw_w;
                h_d   = raw_h;
                col_d = raw_col;
                cx_d  = 8'd0;
                cy_d  = 7'd0;
            end
            S_DRAW: begin
                last_x_d   = pix_x;
                last_y_d   = pix_y;
                last_col_d = col_q;
                if (end_col) begin
                    cx_d = 8'd0;
                    cy_d = end_row ? 7'd0 : cy_q + 7'd1;
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q      <= 2'b00;
            lpy_q      <= 7'd0;
            rpy_q      <= 7'd0;
            bx_q       <= 8'd0;
            by_q       <= 7'd0;
            x0_q       <= 8'd0;
            y0_q       <= 7'd0;
            w_q        <= 8'd0;
            h_q        <= 7'd0;
            col_q      <= 3'b000;
            cx_q       <= 8'd0;
            cy_q       <= 7'd0;
            last_x_q   <= 8'd0;
            last_y_q   <= 7'd0;
            last_col_q <= 3'b000;
        end else begin
            cmd_q      <= cmd_d;
            lpy_q      <= lpy_d;
            rpy_q      <= rpy_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            col_q      <= col_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            last_x_q   <= last_x_d;
            last_y_q   <= last_y_d;
            last_col_q <= last_col_d;
        end
    end

endmodule
